// File: rtl/x_dl_cal_ctrl_pkg.sv
// Shared types and width helpers for the delay-line calibration controller.
// The UART result formatter imports this package as well.
package x_dl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    ACCUM = 2'd2,
    DONE  = 2'd3
  } dl_cal_state_t;

  // Width of an encoded edge position (tap index).
  function automatic int f_pos_w(input int taps);
    return $clog2(taps);
  endfunction

  // Width of the edge-position accumulator: never overflows for 2**log2n edges.
  function automatic int f_sum_w(input int taps, input int log2n);
    return $clog2(taps) + log2n;
  endfunction

endpackage

// File: rtl/x_dl_cal_ctrl_if.sv
// Result channel of the calibration controller.
// Handshake: the master raises o_valid with the result fields stable and keeps
// them unchanged until a cycle where o_valid && i_ready; that cycle is the
// transfer. o_valid never falls without such a transfer. i_ready may toggle freely.
interface x_dl_cal_ctrl_if #(
  parameter int P_W  = 8,
  parameter int P_MW = 10
);
  logic            o_valid;
  logic            i_ready;
  logic            o_err;
  logic [P_W-1:0]  o_min;
  logic [P_W-1:0]  o_max;
  logic [P_W-1:0]  o_mean;
  logic [P_MW-1:0] o_misses;

  modport master (
    output o_valid, o_err, o_min, o_max, o_mean, o_misses,
    input  i_ready
  );

  modport slave (
    input  o_valid, o_err, o_min, o_max, o_mean, o_misses,
    output i_ready
  );
endinterface

// File: rtl/x_dl_cal_ctrl_edge_enc.sv
// Registered first-transition encoder for a tapped delay-line snapshot.
// o_pos is the smallest i (1..P_TAPS-1) where tap i differs from tap i-1;
// either polarity counts. One cycle latency.
module x_dl_edge_enc #(
  parameter int P_TAPS = 256,
  parameter int P_W    = $clog2(P_TAPS)
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic [P_TAPS-1:0] i_data,
  output logic [P_W-1:0]    o_pos,
  output logic              o_hit
);

  logic [P_TAPS-2:0] w_diff;
  logic [P_W-1:0]    w_pos;
  logic              w_hit;
  logic [P_W-1:0]    r_pos;
  logic              r_hit;

  assign w_diff = i_data[P_TAPS-1:1] ^ i_data[P_TAPS-2:0];

  // Priority encode: scanning downward leaves the lowest set difference bit.
  always_comb begin
    w_pos = '0;
    w_hit = 1'b0;
    for (int i = P_TAPS - 2; i >= 0; i--) begin
      if (w_diff[i]) begin
        w_pos = P_W'(i + 1);
        w_hit = 1'b1;
      end
    end
  end

  // Register the encoded result.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_pos <= '0;
      r_hit <= 1'b0;
    end else begin
      r_pos <= w_pos;
      r_hit <= w_hit;
    end
  end

  assign o_pos = r_pos;
  assign o_hit = r_hit;

endmodule

// File: rtl/x_dl_cal_ctrl.sv
// Delay-line calibration controller: accumulates 2**P_LOG2_N edge positions
// and presents min/max/mean/miss count over a valid/ready result channel.
module x_dl_cal_ctrl
  import x_dl_pkg::*;
#(
  parameter int P_TAPS   = 256,
  parameter int P_LOG2_N = 8,
  parameter int P_TO_MUL = 2
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_start,
  input  logic [P_TAPS-1:0] i_data,
  output logic              o_busy,
  output logic [1:0]        o_dbg_state,
  x_dl_cal_ctrl_if.master   res
);

  localparam int W  = f_pos_w(P_TAPS);
  localparam int SW = f_sum_w(P_TAPS, P_LOG2_N);
  localparam int HW = P_LOG2_N + 1;
  localparam int MW = P_LOG2_N + 2;
  localparam int CW = $clog2(P_TO_MUL * (2 ** P_LOG2_N) + 1);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_FLUSH = FLUSH;
  localparam logic [1:0] ST_ACCUM = ACCUM;
  localparam logic [1:0] ST_DONE  = DONE;

  localparam logic [HW-1:0] HIT_TGT = HW'(1) << P_LOG2_N;
  localparam logic [CW-1:0] CYC_TGT = CW'(P_TO_MUL) << P_LOG2_N;

  logic [W-1:0]  w_pos;
  logic          w_hit;

  logic [1:0]    r_state;
  logic          r_flush2;
  logic [SW-1:0] r_sum;
  logic [W-1:0]  r_min_acc;
  logic [W-1:0]  r_max_acc;
  logic [MW-1:0] r_miss_acc;
  logic [HW-1:0] r_hit_cnt;
  logic [CW-1:0] r_cyc_cnt;

  logic          r_err;
  logic [W-1:0]  r_min;
  logic [W-1:0]  r_max;
  logic [W-1:0]  r_mean;
  logic [MW-1:0] r_misses;

  logic [SW-1:0] w_sum_nx;
  logic [W-1:0]  w_min_nx;
  logic [W-1:0]  w_max_nx;
  logic [MW-1:0] w_miss_nx;
  logic [HW-1:0] w_hit_nx;
  logic [CW-1:0] w_cyc_nx;
  logic          w_success;
  logic          w_timeout;

  x_dl_edge_enc #(.P_TAPS(P_TAPS), .P_W(W)) u_enc (
    .i_clk  (i_clk),
    .i_nrst (i_nrst),
    .i_data (i_data),
    .o_pos  (w_pos),
    .o_hit  (w_hit)
  );

  // Accumulator values after folding in the current encoder output.
  always_comb begin
    w_sum_nx  = r_sum;
    w_min_nx  = r_min_acc;
    w_max_nx  = r_max_acc;
    w_miss_nx = r_miss_acc;
    w_hit_nx  = r_hit_cnt;
    w_cyc_nx  = r_cyc_cnt + 1'b1;
    if (w_hit) begin
      w_sum_nx = r_sum + SW'(w_pos);
      w_hit_nx = r_hit_cnt + 1'b1;
      if (w_pos < r_min_acc) w_min_nx = w_pos;
      if (w_pos > r_max_acc) w_max_nx = w_pos;
    end else if (r_miss_acc != '1) begin
      w_miss_nx = r_miss_acc + 1'b1;
    end
    w_success = (w_hit_nx == HIT_TGT);
    w_timeout = (w_cyc_nx == CYC_TGT);
  end

  // Run FSM, accumulators and registered result fields.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state    <= ST_IDLE;
      r_flush2   <= 1'b0;
      r_sum      <= '0;
      r_min_acc  <= '1;
      r_max_acc  <= '0;
      r_miss_acc <= '0;
      r_hit_cnt  <= '0;
      r_cyc_cnt  <= '0;
      r_err      <= 1'b0;
      r_min      <= '0;
      r_max      <= '0;
      r_mean     <= '0;
      r_misses   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state  <= ST_FLUSH;
            r_flush2 <= 1'b0;
          end
        end
        ST_FLUSH: begin
          // Two cycles: the encoder output still reflects pre-start data.
          r_sum      <= '0;
          r_min_acc  <= '1;
          r_max_acc  <= '0;
          r_miss_acc <= '0;
          r_hit_cnt  <= '0;
          r_cyc_cnt  <= '0;
          r_flush2   <= 1'b1;
          if (r_flush2) r_state <= ST_ACCUM;
        end
        ST_ACCUM: begin
          r_sum      <= w_sum_nx;
          r_min_acc  <= w_min_nx;
          r_max_acc  <= w_max_nx;
          r_miss_acc <= w_miss_nx;
          r_hit_cnt  <= w_hit_nx;
          r_cyc_cnt  <= w_cyc_nx;
          if (w_success || w_timeout) begin
            r_state  <= ST_DONE;
            r_err    <= !w_success;
            r_min    <= (w_hit_nx == '0) ? '0 : w_min_nx;
            r_max    <= w_max_nx;
            r_mean   <= W'(w_sum_nx >> P_LOG2_N);
            r_misses <= w_miss_nx;
          end
        end
        default: begin
          if (res.i_ready) r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy       = (r_state != ST_IDLE);
  assign o_dbg_state  = r_state;
  assign res.o_valid  = (r_state == ST_DONE);
  assign res.o_err    = r_err;
  assign res.o_min    = r_min;
  assign res.o_max    = r_max;
  assign res.o_mean   = r_mean;
  assign res.o_misses = r_misses;

endmodule

// File: tb/tb_x_dl_cal_ctrl.sv
// Bench for x_dl_cal_ctrl (P_TAPS=16, P_LOG2_N=2, P_TO_MUL=2).
module tb_x_dl_cal_ctrl;
  import x_dl_pkg::*;

  localparam int P_TAPS   = 16;
  localparam int P_LOG2_N = 2;
  localparam int P_TO_MUL = 2;
  localparam int W        = 4;
  localparam int MW       = 4;
  localparam int N        = 4;

  logic        i_clk   = 1'b0;
  logic        i_nrst  = 1'b0;
  logic        i_start = 1'b0;
  logic [15:0] i_data  = '0;
  logic        o_busy;
  logic [1:0]  o_dbg_state;

  x_dl_cal_ctrl_if #(.P_W(W), .P_MW(MW)) res_if ();

  x_dl_cal_ctrl #(.P_TAPS(P_TAPS), .P_LOG2_N(P_LOG2_N), .P_TO_MUL(P_TO_MUL)) dut (
    .i_clk       (i_clk),
    .i_nrst      (i_nrst),
    .i_start     (i_start),
    .i_data      (i_data),
    .o_busy      (o_busy),
    .o_dbg_state (o_dbg_state),
    .res         (res_if)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] exp_q[$];
  logic [15:0] seq[$];
  int e_edge, e_err, e_min, e_max, e_mean, e_miss;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  // Reference model: first transition of a snapshot, by definition.
  function automatic int first_edge(input logic [15:0] w);
    for (int i = 1; i < 16; i++)
      if (w[i] != w[i-1]) return i;
    return 0;
  endfunction

  // Reference model: walk the accumulated snapshots (from the third driven one)
  // and derive the result and the cycle on which o_valid should appear.
  task automatic model_run();
    int hits = 0, cyc = 0, misses = 0, sum = 0, mn = 99, mx = 0, k = 2, p;
    int err = 0;
    forever begin
      p = first_edge(seq[k % seq.size()]);
      cyc++;
      if (p != 0) begin
        hits++; sum += p;
        if (p < mn) mn = p;
        if (p > mx) mx = p;
      end else if (misses < 15) misses++;
      if (hits == N) begin err = 0; break; end
      if (cyc == P_TO_MUL * N) begin err = 1; break; end
      k++;
    end
    exp_q.push_back(k + 1);
    exp_q.push_back(err);
    exp_q.push_back(hits == 0 ? 0 : mn);
    exp_q.push_back(mx);
    exp_q.push_back(sum / N);
    exp_q.push_back(misses);
  endtask

  task automatic chk_fields(input string tag);
    chk({tag, "_valid"}, res_if.o_valid, 1);
    chk({tag, "_busy"}, o_busy, 1);
    chk({tag, "_err"}, res_if.o_err, e_err);
    chk({tag, "_min"}, res_if.o_min, e_min);
    chk({tag, "_max"}, res_if.o_max, e_max);
    chk({tag, "_mean"}, res_if.o_mean, e_mean);
    chk({tag, "_misses"}, res_if.o_misses, e_miss);
  endtask

  // driver: start a run and stream seq until o_valid or the cycle budget ends
  task automatic run_case(input string tag);
    int vedge = -1;
    model_run();
    e_edge = exp_q.pop_front(); e_err = exp_q.pop_front(); e_min = exp_q.pop_front();
    e_max = exp_q.pop_front(); e_mean = exp_q.pop_front(); e_miss = exp_q.pop_front();
    res_if.i_ready = 1'b0;
    for (int k = 0; k < 40 && vedge < 0; k++) begin
      @(negedge i_clk);
      i_start = (k == 0);
      i_data  = seq[k % seq.size()];
      @(posedge i_clk); #1;
      if (res_if.o_valid) vedge = k;
    end
    @(negedge i_clk);
    i_start = 1'b0;
    chk({tag, "_vcycle"}, vedge, e_edge);
    chk_fields(tag);
  endtask

  // driver: hold i_ready low for `hold` cycles (optional start pulse), then accept
  task automatic accept(input string tag, input int hold, input bit start_pulse, input bit start_at_acc);
    for (int i = 0; i < hold; i++) begin
      i_start = start_pulse && (i == hold / 2);
      @(posedge i_clk); #1;
      chk_fields({tag, "_hold"});
      @(negedge i_clk);
    end
    i_start = start_at_acc;
    res_if.i_ready = 1'b1;
    @(posedge i_clk); #1;
    chk({tag, "_acc_valid"}, res_if.o_valid, 0);
    chk({tag, "_acc_busy"}, o_busy, 0);
    @(negedge i_clk);
    i_start = 1'b0;
    res_if.i_ready = 1'b0;
    @(posedge i_clk); #1;
    chk({tag, "_idle_busy"}, o_busy, 0);
    @(negedge i_clk);
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w, lo;
    int p;
    bit b;
    if ($urandom_range(0, 3) == 0) return ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h0000;
    p  = $urandom_range(1, 15);
    b  = $urandom_range(0, 1);
    w  = 16'($urandom());
    lo = 16'((32'd1 << p) - 1);
    w  = b ? (w | lo) : (w & ~lo);
    w[p] = ~b;
    return w;
  endfunction

  initial begin
    res_if.i_ready = 1'b0;
    #1;
    chk("rst_busy", o_busy, 0);
    chk("rst_valid", res_if.o_valid, 0);
    chk("rst_err", res_if.o_err, 0);
    chk("rst_min", res_if.o_min, 0);
    chk("rst_state", o_dbg_state, 0);
    @(negedge i_clk); @(negedge i_clk);
    i_nrst = 1'b1;

    seq = '{16'h00FF};
    run_case("t1"); accept("t1", 0, 0, 0);
    seq = '{16'h0007, 16'h001F, 16'h003F, 16'h03FF};
    run_case("t2"); accept("t2", 2, 0, 0);
    seq = '{16'h0000};
    run_case("t3"); accept("t3", 1, 0, 0);
    seq = '{16'h000F, 16'h0000};
    run_case("t4a"); accept("t4a", 0, 0, 0);
    seq = '{16'h0000, 16'h000F};
    run_case("t4b"); accept("t4b", 0, 0, 1);
    seq = '{16'h00FF};
    run_case("t5"); accept("t5", 20, 1, 1);

    // reset in the middle of accumulation
    seq = '{16'h00FF};
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      i_start = (k == 0);
      i_data  = seq[0];
    end
    i_start = 1'b0;
    #2 i_nrst = 1'b0;
    #1;
    chk("t6_busy", o_busy, 0);
    chk("t6_valid", res_if.o_valid, 0);
    chk("t6_min", res_if.o_min, 0);
    chk("t6_max", res_if.o_max, 0);
    chk("t6_mean", res_if.o_mean, 0);
    chk("t6_misses", res_if.o_misses, 0);
    @(negedge i_clk);
    i_nrst = 1'b1;
    run_case("t6r"); accept("t6r", 0, 0, 0);

    // randomized runs
    for (int r = 0; r < 12; r++) begin
      int len;
      len = $urandom_range(1, 6);
      seq.delete();
      for (int j = 0; j < len; j++) seq.push_back(rand_word());
      run_case($sformatf("rnd%0d", r));
      accept($sformatf("rnd%0d", r), $urandom_range(0, 5), $urandom_range(0, 1), $urandom_range(0, 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
